// File: rtl/sd_cmd_responder_if.sv
// SD CMD-line bundle: host-side line sampling/driving plus the command/response handshake.
// slave = card responder, master = whatever drives the line and supplies responses.
interface sd_cmd_responder_if;
    logic        sd_cmdIn;
    logic        sd_cmdOut;
    logic        sd_cmdOutActive;
    logic        cmd_valid;
    logic        cmd_err;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_ready;
    logic        resp_valid;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        resp_nocrc;
    logic        busy;

    modport slave (
        input  sd_cmdIn, resp_valid, resp_index, resp_arg, resp_nocrc,
        output sd_cmdOut, sd_cmdOutActive, cmd_valid, cmd_err, cmd_index, cmd_arg,
               resp_ready, busy
    );

    modport master (
        output sd_cmdIn, resp_valid, resp_index, resp_arg, resp_nocrc,
        input  sd_cmdOut, sd_cmdOutActive, cmd_valid, cmd_err, cmd_index, cmd_arg,
               resp_ready, busy
    );
endinterface

// File: rtl/sd_cmd_responder.sv
// SD card CMD responder: 48-bit command RX with CRC7 check, then a 48-bit response NCR clocks after acceptance.
// cmd_valid/cmd_err one clock after the end bit; responses are only taken while resp_ready (WAIT_RESP) is high.
module sd_cmd_responder #(
    parameter int NCR          = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    sd_cmd_responder_if.slave sd
);
    localparam int WW = ($clog2(RESP_TIMEOUT) > 4) ? $clog2(RESP_TIMEOUT) : 4;
    localparam logic [WW-1:0] TMO_LAST = WW'(RESP_TIMEOUT - 1);
    localparam logic [WW-1:0] NCR_LAST = WW'(NCR - 1);

    typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT_RESP, S_NCR_WAIT, S_TX} state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t        state_q, state_d;
    logic [5:0]    rx_cnt_q, rx_cnt_d;
    logic [46:0]   rx_sh_q, rx_sh_d;
    logic [6:0]    crc_q, crc_d;
    logic [5:0]    tx_cnt_q, tx_cnt_d;
    logic [39:0]   tx_sh_q, tx_sh_d;
    logic          nocrc_q, nocrc_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          out_q, out_d;
    logic          oe_q, oe_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_err_q, cmd_err_d;
    logic [5:0]    cmd_index_q, cmd_index_d;
    logic [31:0]   cmd_arg_q, cmd_arg_d;
    logic          resp_ready_q, resp_ready_d;
    logic          busy_q, busy_d;
    logic [47:0]   frame;

    always_comb begin
        state_d     = state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_sh_d     = rx_sh_q;
        crc_d       = crc_q;
        tx_cnt_d    = tx_cnt_q;
        tx_sh_d     = tx_sh_q;
        nocrc_d     = nocrc_q;
        wait_cnt_d  = wait_cnt_q;
        out_d       = 1'b1;
        oe_d        = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        frame       = {rx_sh_q, sd.sd_cmdIn};

        case (state_q)
            S_IDLE: begin
                if (!sd.sd_cmdIn) begin
                    state_d  = S_RX;
                    rx_cnt_d = 6'd1;
                    rx_sh_d  = '0;
                    crc_d    = 7'd0;
                end
            end
            S_RX: begin
                rx_sh_d  = frame[46:0];
                rx_cnt_d = rx_cnt_q + 6'd1;
                if (rx_cnt_q < 6'd40) begin
                    crc_d = crc7_step(crc_q, sd.sd_cmdIn);
                end
                // frame[0] is the end bit arriving on this very clock
                if (rx_cnt_q == 6'd47) begin
                    if (!frame[47] && frame[46] && frame[0] && (frame[7:1] == crc_q)) begin
                        cmd_valid_d = 1'b1;
                        cmd_index_d = frame[45:40];
                        cmd_arg_d   = frame[39:8];
                        state_d     = S_WAIT_RESP;
                        wait_cnt_d  = '0;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (sd.resp_valid) begin
                    tx_sh_d    = {2'b00, sd.resp_index, sd.resp_arg};
                    nocrc_d    = sd.resp_nocrc;
                    state_d    = S_NCR_WAIT;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_NCR_WAIT: begin
                if (wait_cnt_q == NCR_LAST) begin
                    state_d  = S_TX;
                    oe_d     = 1'b1;
                    out_d    = tx_sh_q[39];
                    crc_d    = crc7_step(7'd0, tx_sh_q[39]);
                    tx_sh_d  = {tx_sh_q[38:0], 1'b0};
                    tx_cnt_d = 6'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_TX: begin
                // tx_cnt_q is the index of the bit being set up for the next clock
                oe_d     = 1'b1;
                tx_cnt_d = tx_cnt_q + 6'd1;
                if (tx_cnt_q < 6'd40) begin
                    out_d   = tx_sh_q[39];
                    crc_d   = crc7_step(crc_q, tx_sh_q[39]);
                    tx_sh_d = {tx_sh_q[38:0], 1'b0};
                end else if (tx_cnt_q < 6'd47) begin
                    out_d = nocrc_q | crc_q[6];
                    crc_d = {crc_q[5:0], 1'b0};
                end else if (tx_cnt_q == 6'd47) begin
                    out_d = 1'b1;
                end else begin
                    oe_d     = 1'b0;
                    tx_cnt_d = tx_cnt_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        resp_ready_d = (state_d == S_WAIT_RESP);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_sh_q      <= '0;
            crc_q        <= '0;
            tx_cnt_q     <= '0;
            tx_sh_q      <= '0;
            nocrc_q      <= 1'b0;
            wait_cnt_q   <= '0;
            out_q        <= 1'b1;
            oe_q         <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            cmd_index_q  <= '0;
            cmd_arg_q    <= '0;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_sh_q      <= rx_sh_d;
            crc_q        <= crc_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_sh_q      <= tx_sh_d;
            nocrc_q      <= nocrc_d;
            wait_cnt_q   <= wait_cnt_d;
            out_q        <= out_d;
            oe_q         <= oe_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_err_q    <= cmd_err_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
            resp_ready_q <= resp_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign sd.sd_cmdOut       = out_q;
    assign sd.sd_cmdOutActive = oe_q;
    assign sd.cmd_valid       = cmd_valid_q;
    assign sd.cmd_err         = cmd_err_q;
    assign sd.cmd_index       = cmd_index_q;
    assign sd.cmd_arg         = cmd_arg_q;
    assign sd.resp_ready      = resp_ready_q;
    assign sd.busy            = busy_q;
endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 Parameter NCR, default 2: idle clocks between response acceptance and the response start bit; legal range 2..15.
REQ-002 Parameter RESP_TIMEOUT, default 64: clocks to wait for a response after a good command before abandoning it.
REQ-003 clk  in  1  single clock; it is the SD clock as seen by the card, and all logic uses its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 sd_cmdIn  in  1  sampled CMD line; idles high.
REQ-006 sd_cmdOut  out  1  CMD drive value.
REQ-007 sd_cmdOutActive  out  1  CMD output enable.
REQ-008 cmd_valid  out  1  one-cycle pulse: a good command was received.
REQ-009 cmd_err  out  1  one-cycle pulse: a framing or CRC error was detected.
REQ-010 cmd_index  out  6  index of the last received command.
REQ-011 cmd_arg  out  32  argument of the last received command.
REQ-012 resp_ready  out  1  high when a response can be accepted.
REQ-013 resp_valid  in  1  response request.
REQ-014 resp_index  in  6  response index field (R3 uses 6'h3F).
REQ-015 resp_arg  in  32  response payload.
REQ-016 resp_nocrc  in  1  when 1, the CRC field is sent as 7'h7F (R3 format).
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 The states SHALL be IDLE, RX, WAIT_RESP, NCR_WAIT and TX.
REQ-019 In IDLE, sd_cmdIn=0 SHALL be taken as the start bit, and the state SHALL go to RX with a bit count of 1.
REQ-020 RX SHALL shift in MSB first until all 48 bits are captured (start, transmission, index[5:0], arg[31:0], crc[6:0], end).
REQ-021 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed over bits 47..8 and compared against bits 7..1.
REQ-022 On the clock after the end bit, if transmission=1, end=1 and the CRC matches: pulse cmd_valid, update cmd_index/cmd_arg, and go to WAIT_RESP.
REQ-023 Otherwise on that clock: pulse cmd_err, leave cmd_index/cmd_arg unchanged, and return to IDLE.
REQ-024 cmd_valid and cmd_err SHALL never assert in the same cycle.
REQ-025 resp_ready SHALL be 1 only in WAIT_RESP.
REQ-026 A response is accepted when resp_valid & resp_ready; resp_index, resp_arg and resp_nocrc are latched on that cycle.
REQ-027 resp_valid SHALL be ignored outside WAIT_RESP.
REQ-028 WAIT_RESP SHALL return to IDLE with no output activity if RESP_TIMEOUT clocks elapse without acceptance.
REQ-029 Acceptance at cycle T: NCR_WAIT holds sd_cmdOutActive=0 for NCR clocks, and the start bit is driven at cycle T+1+NCR.
REQ-030 TX SHALL drive 48 bits MSB first, one per clock: 0, 0, resp_index, resp_arg, crc7, 1.
REQ-031 In TX, crc7 SHALL be the CRC7 of the first 40 transmitted bits, or 7'h7F when resp_nocrc=1.
REQ-032 sd_cmdOutActive SHALL be 1 for exactly the 48 TX clocks, then 0, and the state SHALL return to IDLE on the clock after the end bit.
REQ-033 sd_cmdIn SHALL be ignored in WAIT_RESP, NCR_WAIT and TX; no new command is detected until IDLE.
REQ-034 A low on sd_cmdIn in the same cycle the block returns to IDLE SHALL NOT count as a start bit; detection begins on the next cycle.
REQ-035 When sd_cmdOutActive=0, sd_cmdOut SHALL be 1.
REQ-036 The RX bit counter SHALL be 6 bits and the TX bit counter 6 bits, with no wrap beyond 48.

Reset
REQ-037 rst=1 SHALL force the state to IDLE from any state, including mid-RX or mid-TX.
REQ-038 During reset: sd_cmdOutActive=0, sd_cmdOut=1, cmd_valid=0, cmd_err=0, resp_ready=0, busy=0, cmd_index=0, cmd_arg=0, and all counters and CRC registers are 0.
REQ-039 rst asserted mid-TX SHALL release the line on the next clock edge.
REQ-040 The first start bit SHALL be detected on the first clock after rst deasserts.

Verification
REQ-041 Frame 0x40_00000000_95 (CMD0) -> cmd_valid pulse, cmd_index=0, cmd_arg=0, resp_ready=1 on the next cycle.
REQ-042 Frame 0x51_00000000_55 (CMD17) -> cmd_valid, cmd_index=17. Frame 0x51_00000000_57 (bad CRC) -> cmd_err only, resp_ready stays 0.
REQ-043 After CMD0, resp_valid with index=8, arg=0x000001AA at cycle T -> line released T+1..T+2, start bit driven at T+3, 48 bits driven matching a software CRC7 model, sd_cmdOutActive=0 at T+51.
REQ-044 After a good command, no resp_valid for 64 clocks -> back in IDLE with resp_ready=0 and the line never driven.
REQ-045 resp_nocrc=1, index=6'h3F, arg=0x80FF8000 -> transmitted frame 0x3F_80FF8000_FF.
REQ-046 rst pulsed at TX bit 20 -> sd_cmdOutActive=0 on the next clock; a following CMD0 frame -> cmd_valid.
